microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised, table-driven control-sequencer for the SAP-family CPUs.
- Fetch t-states come from fixed parameter words. Execute t-states come from a writable microcode RAM indexed by {opcode, step}, so the instruction set is defined by loaded data rather than RTL.
- Adds conditional micro-steps on a selectable flag, continuous/single-step run modes, runaway-step detection and an instruction-done strobe.
- Sits between the instruction/flags registers and all bus-control inputs of the datapath.

Parameters:
- INSTR_WIDTH, 16, instruction register width.
- OPCODE_LSB, 8, bit position of the opcode field LSB in i_instruction.
- OPCODE_WIDTH, 4, opcode field width; the RAM holds 2^OPCODE_WIDTH rows.
- MAX_STEPS, 8, t-states per instruction, including 2 fetch steps; power of two, at least 4.
- CTRL_WIDTH, 16, number of control lines.
- FLAG_COUNT, 4, number of flag inputs.
- HALT_BIT, 15, index of the halt line within o_control.
- FETCH_WORD0, 16'h4004, control word for step 0 (MAR in, PC out).
- FETCH_WORD1, 16'h1408, control word for step 1 (RAM out, IR in, PC increment).
- Derived: STEP_BITS = clog2(MAX_STEPS); FSEL_BITS = clog2(FLAG_COUNT); UC_WIDTH = CTRL_WIDTH + 2 + FSEL_BITS; UC_ADDR_BITS = OPCODE_WIDTH + STEP_BITS.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous active-high reset, sampled on posedge i_clock.
- i_instruction  in  INSTR_WIDTH  current instruction register contents.
- i_flags  in  FLAG_COUNT  flags register (bit0 overflow/carry, bit1 zero, others free).
- i_run  in  1  1 = advance every clock; 0 = single-step mode.
- i_step_pulse  in  1  in single-step mode, advance one t-state on this cycle.
- i_uc_we  in  1  microcode write enable.
- i_uc_addr  in  UC_ADDR_BITS  write address {opcode, step}.
- i_uc_wdata  in  UC_WIDTH  microcode word.
- o_control  out  CTRL_WIDTH  registered control lines.
- o_step  out  STEP_BITS  t-state that will be issued on the next advance.
- o_halted  out  1  sticky halt indicator.
- o_instr_done  out  1  one-cycle pulse, high while the final t-state's controls are on o_control.
- o_error  out  1  sticky runaway-step error.

Behaviour:
- Microcode word format: [CTRL_WIDTH-1:0] controls; [CTRL_WIDTH] last; [CTRL_WIDTH+1] cond_en; [CTRL_WIDTH+2 +: FSEL_BITS] cond_sel.
- Reset: step=0, o_control=0, o_halted=0, o_instr_done=0, o_error=0. Microcode RAM contents are not reset.
- advance = !o_halted && (i_run || i_step_pulse). Evaluated each posedge when not in reset.
- Latency: controls for step s appear on o_control one clock after the advancing edge that sampled step=s. They remain valid for exactly one cycle.
- Step 0: o_control<=FETCH_WORD0, step<=1. Step 1: o_control<=FETCH_WORD1, step<=2.
- Step s≥2: word = RAM[{opcode,s}], read combinationally.
  - If cond_en=1 and i_flags[cond_sel]=0, o_control<=0 and the instruction ends.
  - Otherwise o_control<=word controls; the instruction ends if last=1, else step<=s+1.
- Instruction end: step<=0 and o_instr_done<=1 on the same edge.
- Runaway: at s=MAX_STEPS-1 with last=0 and the condition passing, treat as end: step<=0, o_instr_done<=1, o_error<=1 (sticky).
- Non-advancing cycle: o_control<=0, o_instr_done<=0, step holds. Controls never repeat across stalls.
- Halt: when the issued controls have HALT_BIT=1, o_halted<=1 on that same edge. From the next cycle o_control holds only HALT_BIT set. Only i_reset clears o_halted.
- i_reset overrides everything, including mid-instruction, and wins over a simultaneous i_uc_we lookup. A RAM write still occurs if i_uc_we=1 during reset.
- Microcode write: RAM[i_uc_addr]<=i_uc_wdata on posedge. Writes to steps 0-1 are stored but never read. A same-edge read of the written address returns old data (read-before-write).
- Opcode is sampled only at steps ≥2. i_instruction changes during fetch have no effect.
- i_step_pulse is ignored while i_run=1. A pulse held high for N cycles gives N advances.

Test Plan:
- Reset, i_run=1, opcode 5 with RAM[{5,2}] = controls 16'h0A00, last=1 → o_control sequence 4004, 1408, 0A00, 4004. o_instr_done high only with 0A00. o_step cycles 1,2,0.
- Two-step ADD, opcode 2: RAM[{2,2}]=16'h1020, last=0; RAM[{2,3}]=16'h0281, last=1 → 4004, 1408, 1020, 0281, then fetch again.
- JZ, opcode 8: RAM[{8,2}] = 16'h1002, cond_en=1, cond_sel=1. i_flags=4'b0010 → 1002 issued. i_flags=0 → 0000 issued. Both cases return to step 0 with o_instr_done=1.
- i_run=0 with pulses every 3rd cycle → each fetch/exec word lasts one cycle, zeros in between, o_step advances only on pulses.
- HLT word 16'h8000, last=1 → o_halted=1; o_control stays 8000 for 20 cycles despite i_run. Reset mid-halt → fetch restarts at 4004. Reset asserted at step 3 of ADD → next advance issues 4004.
- Opcode 3 whose words are all last=0 → steps 2..7 issued, then o_error=1, o_instr_done=1, step returns to 0, and o_error stays set until reset.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Table-driven control sequencer: fixed fetch words, RAM-defined execute steps.
// Supports conditional steps, single-step mode, halt and runaway detection.
module microcode_sequencer #(
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_LSB   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_STEPS    = 8,
    parameter int CTRL_WIDTH   = 16,
    parameter int FLAG_COUNT   = 4,
    parameter int HALT_BIT     = 15,
    parameter logic [CTRL_WIDTH-1:0] FETCH_WORD0 = 16'h4004,
    parameter logic [CTRL_WIDTH-1:0] FETCH_WORD1 = 16'h1408,
    localparam int STEP_BITS    = $clog2(MAX_STEPS),
    localparam int FSEL_BITS    = $clog2(FLAG_COUNT),
    localparam int UC_WIDTH     = CTRL_WIDTH + 2 + FSEL_BITS,
    localparam int UC_ADDR_BITS = OPCODE_WIDTH + STEP_BITS
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [INSTR_WIDTH-1:0]  i_instruction,
    input  logic [FLAG_COUNT-1:0]   i_flags,
    input  logic                    i_run,
    input  logic                    i_step_pulse,
    input  logic                    i_uc_we,
    input  logic [UC_ADDR_BITS-1:0] i_uc_addr,
    input  logic [UC_WIDTH-1:0]     i_uc_wdata,
    output logic [CTRL_WIDTH-1:0]   o_control,
    output logic [STEP_BITS-1:0]    o_step,
    output logic                    o_halted,
    output logic                    o_instr_done,
    output logic                    o_error
);

    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(MAX_STEPS - 1);
    localparam logic [STEP_BITS-1:0] STEP_ONE  = STEP_BITS'(1);
    localparam logic [CTRL_WIDTH-1:0] HALT_MASK = CTRL_WIDTH'(1) << HALT_BIT;

    logic [UC_WIDTH-1:0]     mem [2**UC_ADDR_BITS];
    logic [STEP_BITS-1:0]    step;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [UC_WIDTH-1:0]     word;
    logic [CTRL_WIDTH-1:0]   uc_ctl;
    logic                    uc_last;
    logic                    uc_cond_en;
    logic [FSEL_BITS-1:0]    uc_cond_sel;
    logic                    cond_fail;
    logic                    advance;
    logic [CTRL_WIDTH-1:0]   nxt_ctl;
    logic                    ends;
    logic                    runaway;
    logic                    unused_instr_bits;

    assign opcode      = i_instruction[OPCODE_LSB +: OPCODE_WIDTH];
    assign word        = mem[{opcode, step}];
    assign uc_ctl      = word[CTRL_WIDTH-1:0];
    assign uc_last     = word[CTRL_WIDTH];
    assign uc_cond_en  = word[CTRL_WIDTH+1];
    assign uc_cond_sel = word[CTRL_WIDTH+2 +: FSEL_BITS];
    assign cond_fail   = uc_cond_en && !i_flags[uc_cond_sel];
    assign advance     = !o_halted && (i_run || i_step_pulse);
    assign o_step      = step;

    assign unused_instr_bits =
        ^{i_instruction[INSTR_WIDTH-1:OPCODE_LSB+OPCODE_WIDTH],
          i_instruction[OPCODE_LSB-1:0]};

    // Microcode store; read above sees the pre-write contents on the same edge.
    always_ff @(posedge i_clock) begin
        if (i_uc_we)
            mem[i_uc_addr] <= i_uc_wdata;
    end

    // Pick the word to issue for the current step and decide if it ends the instruction.
    always_comb begin
        nxt_ctl = '0;
        ends    = 1'b0;
        runaway = 1'b0;
        unique case (1'b1)
            (step == '0): nxt_ctl = FETCH_WORD0;
            (step == STEP_ONE): nxt_ctl = FETCH_WORD1;
            (step > STEP_ONE && cond_fail): ends = 1'b1;
            default: begin
                nxt_ctl = uc_ctl;
                if (uc_last) begin
                    ends = 1'b1;
                end else if (step == LAST_STEP) begin
                    ends    = 1'b1;
                    runaway = 1'b1;
                end
            end
        endcase
    end

    // Step counter, registered control lines and sticky status flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            step         <= '0;
            o_control    <= '0;
            o_halted     <= 1'b0;
            o_instr_done <= 1'b0;
            o_error      <= 1'b0;
        end else if (o_halted) begin
            o_control    <= HALT_MASK;
            o_instr_done <= 1'b0;
        end else if (!advance) begin
            o_control    <= '0;
            o_instr_done <= 1'b0;
        end else begin
            o_control    <= nxt_ctl;
            o_instr_done <= ends;
            step         <= ends ? '0 : step + STEP_ONE;
            if (runaway)
                o_error <= 1'b1;
            if (nxt_ctl[HALT_BIT])
                o_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: expected outputs are queued
// per driven cycle and compared on the following falling edge.
module tb_microcode_sequencer;

    typedef struct {
        logic [15:0] ctl;
        logic [2:0]  step;
        logic [2:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic        run;
    logic        pulse;
    logic        we;
    logic [6:0]  waddr;
    logic [19:0] wdata;
    logic [15:0] ctl;
    logic [2:0]  step;
    logic        halted;
    logic        done;
    logic        err;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    microcode_sequencer dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_instruction (instr),
        .i_flags       (flags),
        .i_run         (run),
        .i_step_pulse  (pulse),
        .i_uc_we       (we),
        .i_uc_addr     (waddr),
        .i_uc_wdata    (wdata),
        .o_control     (ctl),
        .o_step        (step),
        .o_halted      (halted),
        .o_instr_done  (done),
        .o_error       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Monitor: pop the expectation queued for the edge just gone.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("control", {16'h0, ctl}, {16'h0, e.ctl});
            chk("step", {29'h0, step}, {29'h0, e.step});
            chk("halt/err/done", {29'h0, halted, err, done},
                {29'h0, e.flg});
        end
    end

    task automatic tick(input logic [15:0] c, input logic [2:0] s,
                        input logic d, input logic h, input logic e);
        exp_t x;
        x.ctl  = c;
        x.step = s;
        x.flg  = {h, e, d};
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [19:0] ucw(input logic [1:0] sel,
                                        input logic cen, input logic last,
                                        input logic [15:0] c);
        return {sel, cen, last, c};
    endfunction

    task automatic uc_write(input logic [3:0] op, input logic [2:0] st,
                            input logic [19:0] w);
        we    = 1'b1;
        waddr = {op, st};
        wdata = w;
        tick(16'h0, 3'd0, 0, 0, 0);
        we = 1'b0;
    endtask

    initial begin
        rst = 1; instr = 16'h0; flags = 4'h0; run = 0; pulse = 0;
        we = 0; waddr = '0; wdata = '0;
        tick(16'h0, 3'd0, 0, 0, 0);
        tick(16'h0, 3'd0, 0, 0, 0);

        // Program loaded while reset is held.
        uc_write(4'd5, 3'd2, ucw(2'd0, 0, 1, 16'h0A00));
        uc_write(4'd2, 3'd2, ucw(2'd0, 0, 0, 16'h1020));
        uc_write(4'd2, 3'd3, ucw(2'd0, 0, 1, 16'h0281));
        uc_write(4'd8, 3'd2, ucw(2'd1, 1, 1, 16'h1002));
        uc_write(4'd15, 3'd2, ucw(2'd0, 0, 1, 16'h8000));
        for (int s = 2; s < 8; s++)
            uc_write(4'd3, 3'(s), ucw(2'd0, 0, 0, 16'h0010 + 16'(s)));

        // Single-step LDA-style opcode 5.
        rst = 0; run = 1; instr = 16'h0500;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h0A00, 3'd0, 1, 0, 0);
        tick(16'h4004, 3'd1, 0, 0, 0);

        // Two-step ADD; opcode swapped during fetch.
        instr = 16'h0200;
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h1020, 3'd3, 0, 0, 0);
        tick(16'h0281, 3'd0, 1, 0, 0);
        tick(16'h4004, 3'd1, 0, 0, 0);

        // JZ: condition true then false.
        instr = 16'h0800; flags = 4'b0010;
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h1002, 3'd0, 1, 0, 0);
        tick(16'h4004, 3'd1, 0, 0, 0);
        flags = 4'b0000;
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h0000, 3'd0, 1, 0, 0);

        // Single-step mode, pulse every third cycle.
        run = 0; flags = 4'b0010;
        pulse = 1; tick(16'h4004, 3'd1, 0, 0, 0);
        pulse = 0; tick(16'h0, 3'd1, 0, 0, 0);
        tick(16'h0, 3'd1, 0, 0, 0);
        pulse = 1; tick(16'h1408, 3'd2, 0, 0, 0);
        pulse = 0; tick(16'h0, 3'd2, 0, 0, 0);
        tick(16'h0, 3'd2, 0, 0, 0);
        pulse = 1; tick(16'h1002, 3'd0, 1, 0, 0);
        pulse = 0; tick(16'h0, 3'd0, 0, 0, 0);
        tick(16'h0, 3'd0, 0, 0, 0);
        // Pulse held two cycles gives two advances.
        pulse = 1; tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        pulse = 0; tick(16'h0, 3'd2, 0, 0, 0);
        pulse = 1; tick(16'h1002, 3'd0, 1, 0, 0);
        pulse = 0;

        // Same-edge rewrite of the word being read returns old data.
        run = 1;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        we = 1; waddr = {4'd8, 3'd2}; wdata = ucw(2'd0, 0, 1, 16'h0003);
        tick(16'h1002, 3'd0, 1, 0, 0);
        we = 0;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h0003, 3'd0, 1, 0, 0);

        // Reset in the middle of ADD restarts at fetch.
        instr = 16'h0200;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h1020, 3'd3, 0, 0, 0);
        rst = 1; tick(16'h0, 3'd0, 0, 0, 0);
        rst = 0; tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h1020, 3'd3, 0, 0, 0);
        tick(16'h0281, 3'd0, 1, 0, 0);

        // Runaway opcode 3: steps 2..7 then forced end with sticky error.
        instr = 16'h0300;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        for (int s = 2; s < 7; s++)
            tick(16'h0010 + 16'(s), 3'(s + 1), 0, 0, 0);
        tick(16'h0017, 3'd0, 1, 0, 1);
        tick(16'h4004, 3'd1, 0, 0, 1);
        tick(16'h1408, 3'd2, 0, 0, 1);
        instr = 16'h0500;
        tick(16'h0A00, 3'd0, 1, 0, 1);

        // Halt: sticky, ignores run and pulses, cleared only by reset.
        instr = 16'h0F00;
        tick(16'h4004, 3'd1, 0, 0, 1);
        tick(16'h1408, 3'd2, 0, 0, 1);
        tick(16'h8000, 3'd0, 1, 1, 1);
        for (int i = 0; i < 20; i++) begin
            pulse = (i % 4 == 0);
            tick(16'h8000, 3'd0, 0, 1, 1);
        end
        pulse = 0;
        rst = 1; tick(16'h0, 3'd0, 0, 0, 0);
        rst = 0; instr = 16'h0500;
        tick(16'h4004, 3'd1, 0, 0, 0);
        tick(16'h1408, 3'd2, 0, 0, 0);
        tick(16'h0A00, 3'd0, 1, 0, 0);

        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
